dut_ctrl_bridge: RTL

DUT_CTRL_BRIDGE -- requirements
Module: dut_ctrl_bridge

---
 rtl/dut_ctrl_bridge.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dut_ctrl_bridge.sv
// dut_ctrl_bridge: bridges a hold-until-served control command port onto a
// simple strobe-based slave bus, and decimates a continuous sample stream.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   ctrl_ready_i/write_i      command valid / write(1) or read(0)
//   ctrl_addr_i/data_i        command address / write data
//   dut_cwait_o               stall: source holds its command while high
//   dut_cready_o/data_o/addr_o one-cycle read response with data and address
//   bus_addr_o/wdata_o        slave address / write data
//   bus_wen_o/ren_o           single-cycle write / read strobes
//   bus_rdata_i/ack_i         slave read data / read acknowledge
//   sample_data_i             continuous sample stream
//   dut_sample_o/sready_o     decimated sample / one-cycle strobe
//   err_o                     sticky read-timeout flag
//
// Optional feature: define DUT_CTRL_TIMEOUT_EN to give ACK_MODE reads a
// TMO-cycle timeout that returns a poison word and sets err_o.
module dut_ctrl_bridge #(
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter int            SW       = 16,
  parameter int            WAIT     = 1,
  parameter int            ACK_MODE = 0,
  parameter logic [AW-1:0] BASE     = 16'h0100,
  parameter logic [AW-1:0] MASK     = 16'hFF00,
  parameter int            DEC      = 1,
  parameter int            TMO      = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          ctrl_ready_i,
  input  logic          ctrl_write_i,
  input  logic [AW-1:0] ctrl_addr_i,
  input  logic [DW-1:0] ctrl_data_i,
  output logic          dut_cwait_o,
  output logic          dut_cready_o,
  output logic [DW-1:0] dut_data_o,
  output logic [AW-1:0] dut_addr_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic          bus_wen_o,
  output logic          bus_ren_o,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_ack_i,
  input  logic [SW-1:0] sample_data_i,
  output logic [SW-1:0] dut_sample_o,
  output logic          dut_sready_o,
  output logic          err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_e;

  localparam int DCW = (DEC > 1) ? $clog2(DEC) : 1;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [2:0]     wcnt_q, wcnt_d;
  logic [DCW-1:0] dcnt_q;
  logic [SW-1:0]  smp_q;
  logic           srdy_q;
  logic           hit, rd_acc, cwait, cready, ren, wen;

`ifdef DUT_CTRL_TIMEOUT_EN
  localparam int          TW       = $clog2(TMO + 1);
  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  assign hit    = (ctrl_addr_i & MASK) == BASE;
  assign rd_acc = ctrl_ready_i & ~ctrl_write_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    cwait   = 1'b0;
    cready  = 1'b0;
    ren     = 1'b0;
    wen     = 1'b0;
`ifdef DUT_CTRL_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          // Stall is raised combinationally on acceptance so the source keeps
          // its command steady until the response strobe.
          cwait  = 1'b1;
          addr_d = ctrl_addr_i;
          wcnt_d = '0;
`ifdef DUT_CTRL_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (hit) begin
            ren     = 1'b1;
            state_d = S_WAIT;
          end else begin
            data_d  = '0;
            state_d = S_RESP;
          end
        end else if (ctrl_ready_i && hit) begin
          wen = 1'b1;
        end
      end
      S_WAIT: begin
        cwait = 1'b1;
        if (ACK_MODE != 0) begin
          if (bus_ack_i) begin
            data_d  = bus_rdata_i;
            state_d = S_RESP;
          end
`ifdef DUT_CTRL_TIMEOUT_EN
          else if (tcnt_q == TW'(TMO - 1)) begin
            data_d  = DW'(TMO_DATA);
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end else begin
          // WAIT=0 and WAIT=1 both sample on the first cycle in this state.
          if (({1'b0, wcnt_q} + 4'd1) >= 4'(WAIT)) begin
            data_d  = bus_rdata_i;
            state_d = S_RESP;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      S_RESP: begin
        cready  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Only a fresh command (dropped ready or new address) re-arms IDLE.
        if (!ctrl_ready_i || (ctrl_addr_i != addr_q)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef DUT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
  assign err_o = err_q & ~reset_i;
`else
  assign err_o = 1'b0;
`endif

  // Decimator: the output sample and its strobe change on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dcnt_q <= '0;
      smp_q  <= '0;
      srdy_q <= 1'b0;
    end else begin
      srdy_q <= (dcnt_q == DCW'(DEC - 1));
      if (dcnt_q == DCW'(DEC - 1)) begin
        dcnt_q <= '0;
        smp_q  <= sample_data_i;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  assign dut_cwait_o  = cwait  & ~reset_i;
  assign dut_cready_o = cready & ~reset_i;
  assign bus_ren_o    = ren    & ~reset_i;
  assign bus_wen_o    = wen    & ~reset_i;
  assign dut_sready_o = srdy_q & ~reset_i;
  assign dut_data_o   = reset_i ? '0 : data_q;
  assign dut_addr_o   = reset_i ? '0 : addr_q;
  assign dut_sample_o = reset_i ? '0 : smp_q;
  assign bus_addr_o   = (state_q == S_WAIT) ? addr_q : ctrl_addr_i;
  assign bus_wdata_o  = ctrl_data_i;

endmodule
